serial_seq_gen: RTL and testbench

Serial pattern generator directly upstream of the serial sequence detector. On a start request it captures a WIDTH-bit pattern and shifts it out MSB-first, one bit per clock, repeating it a programmable number of times with a programmable idle gap between frames. Its default pattern, 12'hEDB, is the detector's target, so the pair can be exercised end-to-end. Bit order matches the detector's shift-in order, so a transmitted frame lands in the detector's register with its MSB at the top.

---
 rtl/serial_seq_gen_pkg.sv | 19 +
 rtl/serial_seq_gen_if.sv | 34 +++
 rtl/load_dn_cnt.sv | 33 +++
 rtl/serial_seq_gen.sv | 166 ++++++++++++++++
 tb/tb_serial_seq_gen.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/serial_seq_gen_pkg.sv
// Shared types and defaults for the serial pattern generator.
//   state_t      : FSM encoding (IDLE, SHIFT, GAP, DONE)
//   DEF_PATTERN  : default frame, the downstream detector's target word
//   DEF_*        : default parameter widths
package serial_seq_gen_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    GAP,
    DONE
  } state_t;

  localparam int unsigned DEF_WIDTH   = 12;
  localparam int unsigned DEF_CNT_W   = 4;
  localparam int unsigned DEF_GAP_W   = 4;
  localparam logic [11:0] DEF_PATTERN = 12'hEDB;

endpackage

// File: rtl/serial_seq_gen_if.sv
// Control/data bundle between a requester and serial_seq_gen.
//   master : drives start_i, use_default_i, pattern_i, repeat_i, gap_i, abort_i;
//            observes x_o, x_vld_o, busy_o, done_o
//   slave  : the generator side (mirror of master)
interface serial_seq_gen_if
  import serial_seq_gen_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned CNT_W = DEF_CNT_W,
  parameter int unsigned GAP_W = DEF_GAP_W
) ();

  logic             start_i;
  logic             use_default_i;
  logic [WIDTH-1:0] pattern_i;
  logic [CNT_W-1:0] repeat_i;
  logic [GAP_W-1:0] gap_i;
  logic             abort_i;
  logic             x_o;
  logic             x_vld_o;
  logic             busy_o;
  logic             done_o;

  modport master (
    output start_i, use_default_i, pattern_i, repeat_i, gap_i, abort_i,
    input  x_o, x_vld_o, busy_o, done_o
  );

  modport slave (
    input  start_i, use_default_i, pattern_i, repeat_i, gap_i, abort_i,
    output x_o, x_vld_o, busy_o, done_o
  );

endinterface

// File: rtl/load_dn_cnt.sv
// Loadable down-counter with zero flag. Load has priority over decrement;
// decrementing saturates at zero.
//   clk, reset : clock, synchronous active-high reset
//   load_i     : load load_val_i this cycle
//   load_val_i : value to load
//   dec_i      : decrement by one (ignored at zero)
//   zero_o     : count is zero (combinational from the count register)
module load_dn_cnt #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic         zero_o
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (load_i) begin
      cnt <= load_val_i;
    end else if (dec_i && (cnt != '0)) begin
      cnt <= cnt - W'(1);
    end
  end

  assign zero_o = (cnt == '0);

endmodule

// File: rtl/serial_seq_gen.sv
// Serial pattern generator. On an accepted start it captures a WIDTH-bit
// pattern and shifts it out MSB-first, (repeat+1) times, with gap idle
// cycles between frames. All outputs are registered.
//   clk, reset : clock, synchronous active-high reset
//   bus        : serial_seq_gen_if.slave (start/pattern/repeat/gap/abort in;
//                x_o, x_vld_o, busy_o, done_o out)
module serial_seq_gen
  import serial_seq_gen_pkg::*;
#(
  parameter int unsigned      WIDTH   = DEF_WIDTH,
  parameter logic [WIDTH-1:0] PATTERN = DEF_PATTERN,
  parameter int unsigned      CNT_W   = DEF_CNT_W,
  parameter int unsigned      GAP_W   = DEF_GAP_W
) (
  input logic             clk,
  input logic             reset,
  serial_seq_gen_if.slave bus
);

  localparam int unsigned      BIT_W    = $clog2(WIDTH);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] pat_q;
  logic [WIDTH-1:0] shreg;
  logic [GAP_W-1:0] gap_q;
  logic             x_q, vld_q, busy_q, done_q;
  logic [WIDTH-1:0] start_pat;

  logic             bit_load, bit_dec, bit_zero;
  logic             gap_load, gap_dec, gap_zero;
  logic             frm_load, frm_dec, frm_zero;

  assign start_pat = bus.use_default_i ? PATTERN : bus.pattern_i;

  // The output register already holds the bit being sent, so shreg keeps
  // the bits still to come; bit counter value = bits left after the current.
  load_dn_cnt #(.W(BIT_W)) u_bit_cnt (
    .clk(clk), .reset(reset),
    .load_i(bit_load), .load_val_i(BIT_LAST),
    .dec_i(bit_dec), .zero_o(bit_zero)
  );

  load_dn_cnt #(.W(GAP_W)) u_gap_cnt (
    .clk(clk), .reset(reset),
    .load_i(gap_load), .load_val_i(gap_q - GAP_W'(1)),
    .dec_i(gap_dec), .zero_o(gap_zero)
  );

  // Frames remaining after the current one; one extra bit of range.
  load_dn_cnt #(.W(CNT_W + 1)) u_frm_cnt (
    .clk(clk), .reset(reset),
    .load_i(frm_load), .load_val_i({1'b0, bus.repeat_i}),
    .dec_i(frm_dec), .zero_o(frm_zero)
  );

  always_comb begin
    bit_load = 1'b0;
    bit_dec  = 1'b0;
    gap_load = 1'b0;
    gap_dec  = 1'b0;
    frm_load = 1'b0;
    frm_dec  = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start_i) begin
          bit_load = 1'b1;
          frm_load = 1'b1;
        end
      end
      SHIFT: begin
        if (!bit_zero) begin
          bit_dec = 1'b1;
        end else if (!frm_zero) begin
          frm_dec = 1'b1;
          if (gap_q != '0) gap_load = 1'b1;
          else             bit_load = 1'b1;
        end
      end
      GAP: begin
        if (!gap_zero) gap_dec  = 1'b1;
        else           bit_load = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      pat_q  <= '0;
      shreg  <= '0;
      gap_q  <= '0;
      x_q    <= 1'b0;
      vld_q  <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          x_q    <= 1'b0;
          vld_q  <= 1'b0;
          busy_q <= 1'b0;
          done_q <= 1'b0;
          if (bus.start_i) begin
            pat_q  <= start_pat;
            gap_q  <= bus.gap_i;
            x_q    <= start_pat[WIDTH-1];
            shreg  <= {start_pat[WIDTH-2:0], 1'b0};
            vld_q  <= 1'b1;
            busy_q <= 1'b1;
            state  <= SHIFT;
          end
        end
        SHIFT: begin
          if (bus.abort_i) begin
            x_q    <= 1'b0;
            vld_q  <= 1'b0;
            busy_q <= 1'b0;
            state  <= IDLE;
          end else if (!bit_zero) begin
            x_q   <= shreg[WIDTH-1];
            shreg <= {shreg[WIDTH-2:0], 1'b0};
          end else if (!frm_zero) begin
            if (gap_q != '0) begin
              x_q   <= 1'b0;
              vld_q <= 1'b0;
              state <= GAP;
            end else begin
              x_q   <= pat_q[WIDTH-1];
              shreg <= {pat_q[WIDTH-2:0], 1'b0};
            end
          end else begin
            x_q    <= 1'b0;
            vld_q  <= 1'b0;
            done_q <= 1'b1;
            state  <= DONE;
          end
        end
        GAP: begin
          if (bus.abort_i) begin
            busy_q <= 1'b0;
            state  <= IDLE;
          end else if (gap_zero) begin
            x_q   <= pat_q[WIDTH-1];
            shreg <= {pat_q[WIDTH-2:0], 1'b0};
            vld_q <= 1'b1;
            state <= SHIFT;
          end
        end
        DONE: begin
          done_q <= 1'b0;
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.x_o     = x_q;
  assign bus.x_vld_o = vld_q;
  assign bus.busy_o  = busy_q;
  assign bus.done_o  = done_q;

endmodule

// File: tb/tb_serial_seq_gen.sv
module tb_serial_seq_gen;
  import serial_seq_gen_pkg::*;

  localparam int W = 12;

  typedef struct {
    logic        use_def;
    logic [11:0] pat;
    logic [3:0]  rep;
    logic [3:0]  gap;
    int          exp_done;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  logic det_clr;
  logic [11:0] det_sr;
  logic det_o;
  int errors = 0;
  int checks = 0;
  vec_t tbl[6];

  always #5 clk = ~clk;

  serial_seq_gen_if #(.WIDTH(12), .CNT_W(4), .GAP_W(4)) bus ();

  serial_seq_gen #(.WIDTH(12), .PATTERN(12'hEDB), .CNT_W(4), .GAP_W(4)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  // Downstream detector stand-in: shifts in valid bits, flags 12'hEDB.
  always @(posedge clk) begin
    if (det_clr) begin
      det_sr <= '0;
      det_o  <= 1'b0;
    end else if (bus.x_vld_o) begin
      det_sr <= {det_sr[10:0], bus.x_o};
      det_o  <= ({det_sr[10:0], bus.x_o} == 12'hEDB);
    end else begin
      det_o <= 1'b0;
    end
  end

  task automatic chk(input string name, input int c, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, c, act, exp);
    end
  endtask

  function automatic bit m_vld(input int c, input int rep, input int gap);
    int n, off;
    if (c < 1) return 1'b0;
    n   = (c - 1) / (W + gap);
    off = (c - 1) % (W + gap);
    return (n <= rep) && (off < W);
  endfunction

  function automatic bit m_x(input int c, input int rep, input int gap, input logic [11:0] pat);
    int off;
    if (!m_vld(c, rep, gap)) return 1'b0;
    off = (c - 1) % (W + gap);
    return pat[W-1-off];
  endfunction

  function automatic bit m_det(input int c, input int rep, input int gap, input logic use_def);
    if (!use_def || !m_vld(c - 1, rep, gap)) return 1'b0;
    return ((c - 2) % (W + gap)) == (W - 1);
  endfunction

  // Called at a negedge; start is accepted on the following posedge (edge T).
  task automatic kick(input logic ud, input logic [11:0] pat, input logic [3:0] rep, input logic [3:0] gap);
    bus.use_default_i = ud;
    bus.pattern_i     = pat;
    bus.repeat_i      = rep;
    bus.gap_i         = gap;
    bus.start_i       = 1'b1;
    det_clr           = 1'b1;
    @(posedge clk);
    #1;
    bus.start_i = 1'b0;
    det_clr     = 1'b0;
  endtask

  task automatic wait_idle();
    int k = 0;
    while (bus.busy_o && k < 80) begin
      @(negedge clk);
      k++;
    end
    chk("idle_wait", k, bus.busy_o, 0);
  endtask

  initial begin
    logic [11:0] p;
    logic [3:0]  rp, gp;
    logic        ud;
    int          d;

    tbl[0] = '{1'b1, 12'h000, 4'd0, 4'd0, 13};
    tbl[1] = '{1'b0, 12'hA5C, 4'd2, 4'd3, 43};
    tbl[2] = '{1'b1, 12'h000, 4'd1, 4'd0, 25};
    tbl[3] = '{1'b0, 12'h001, 4'd3, 4'd1, 52};
    tbl[4] = '{1'b0, 12'h800, 4'd0, 4'd5, 13};
    tbl[5] = '{1'b1, 12'h123, 4'd2, 4'd0, 37};

    // Reset with start held high: outputs stay 0 throughout.
    reset             = 1'b1;
    det_clr           = 1'b1;
    bus.start_i       = 1'b1;
    bus.use_default_i = 1'b1;
    bus.pattern_i     = '0;
    bus.repeat_i      = '0;
    bus.gap_i         = '0;
    bus.abort_i       = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("rst_outs", i, {bus.x_o, bus.x_vld_o, bus.busy_o, bus.done_o}, 0);
    end
    reset = 1'b0;
    @(posedge clk);
    #1;
    bus.start_i = 1'b0;
    det_clr     = 1'b0;
    @(negedge clk);
    chk("post_rst_first_bit", 1, {bus.x_o, bus.x_vld_o, bus.busy_o}, 3'b111);
    wait_idle();

    // Table-driven frames.
    for (int i = 0; i < 6; i++) begin
      ud = tbl[i].use_def; p = tbl[i].pat; rp = tbl[i].rep; gp = tbl[i].gap; d = tbl[i].exp_done;
      if (ud) p = 12'hEDB;
      kick(ud, tbl[i].pat, rp, gp);
      for (int c = 1; c <= d + 1; c++) begin
        @(negedge clk);
        chk("x_o",     c, bus.x_o,     m_x(c, rp, gp, p));
        chk("x_vld_o", c, bus.x_vld_o, m_vld(c, rp, gp));
        chk("done_o",  c, bus.done_o,  c == d);
        chk("busy_o",  c, bus.busy_o,  c <= d);
        chk("det_o",   c, det_o,       m_det(c, rp, gp, ud));
      end
    end

    // Abort in cycle T+5, restart at T+6 with 12'h800.
    kick(1'b1, 12'h000, 4'd0, 4'd0);
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (c <= 5) chk("abort_x_o", c, bus.x_o, m_x(c, 0, 0, 12'hEDB));
      if (c == 6) chk("abort_outs", c, {bus.x_o, bus.x_vld_o, bus.busy_o, bus.done_o}, 0);
      if (c == 7) chk("restart_first", c, {bus.x_o, bus.x_vld_o, bus.busy_o}, 3'b111);
      chk("abort_done", c, bus.done_o, c == 19);
      if (c == 5) bus.abort_i = 1'b1;
      if (c == 6) begin
        bus.abort_i       = 1'b0;
        bus.use_default_i = 1'b0;
        bus.pattern_i     = 12'h800;
        bus.start_i       = 1'b1;
      end
      if (c == 7) bus.start_i = 1'b0;
    end
    chk("abort_idle", 20, bus.busy_o, 0);

    // start_i and input changes while busy are ignored.
    kick(1'b0, 12'hA5C, 4'd0, 4'd0);
    for (int c = 1; c <= 15; c++) begin
      @(negedge clk);
      chk("busy_x_o",  c, bus.x_o,     m_x(c, 0, 0, 12'hA5C));
      chk("busy_vld",  c, bus.x_vld_o, m_vld(c, 0, 0));
      chk("busy_done", c, bus.done_o,  c == 13);
      chk("busy_busy", c, bus.busy_o,  c <= 13);
      if (c == 4) begin
        bus.start_i       = 1'b1;
        bus.pattern_i     = 12'hFFF;
        bus.use_default_i = 1'b1;
        bus.repeat_i      = 4'd5;
        bus.gap_i         = 4'd2;
      end
      if (c == 5) bus.start_i = 1'b0;
    end

    // abort_i together with start_i in IDLE: start wins.
    bus.abort_i = 1'b1;
    kick(1'b1, 12'h000, 4'd0, 4'd0);
    bus.abort_i = 1'b0;
    @(negedge clk);
    chk("abort_start_idle", 1, {bus.x_o, bus.x_vld_o, bus.busy_o}, 3'b111);
    wait_idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
